// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Client-side bundle for the UART transmitter: FIFO write port,
//               FIFO status flags and the serial line/frame status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       tx;
  logic       busy;
  logic       done;

  // Client side: pushes bytes, observes status and the line
  modport master (
    output wr_en, wr_data,
    input  full, empty, tx, busy, done
  );

  // Transmitter side
  modport slave (
    input  wr_en, wr_data,
    output full, empty, tx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : 8N1 UART transmitter fed by a small byte FIFO. Queued bytes
//               are sent back to back with no idle gap between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          nrst,
  uart_tx_fifo_if.slave bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  state_t            state;
  state_t            state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_next;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_next;
  logic [7:0]        shift;
  logic [7:0]        shift_next;
  logic              tx_line;
  logic              tx_next;
  logic              busy;
  logic              bit_end;
  logic              last_stop;

  // Flags come from the registered count; a write while full is dropped even
  // if the transmitter pops in the same cycle.
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = bus.wr_en & ~fifo_full;
  assign bit_end    = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  // In STOP, bit_idx counts stop bits rather than data bits.
  assign last_stop  = (bit_idx == 3'(STOP_BITS - 1));

  assign bus.full  = fifo_full;
  assign bus.empty = fifo_empty;
  assign bus.tx    = tx_line;
  assign bus.busy  = busy;
  assign bus.done  = (state == STOP) && bit_end && last_stop;

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Transmitter state, counters, shifter and registered line/busy outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_line  <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx_line  <= tx_next;
      busy     <= (state_next != IDLE);
    end
  end

  // Next-state logic; the shifter is loaded only when the head byte is popped
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx_line;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = 1'b0;
          state_next = START;
        end
      end

      START: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = shift[0];
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            bit_next   = '0;
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            // Next bit on the line is the one that lands in shift[0]
            shift_next = {1'b0, shift[7:1]};
            bit_next   = bit_idx + 3'd1;
            tx_next    = shift[1];
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          if (last_stop) begin
            bit_next = '0;
            if (!fifo_empty) begin
              // Chain straight into the next start bit, no idle gap
              pop        = 1'b1;
              shift_next = mem[rd_ptr];
              tx_next    = 1'b0;
              state_next = START;
            end else begin
              tx_next    = 1'b1;
              state_next = IDLE;
            end
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
